prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream (sync, count, little-endian words,
// checksum) into 32-bit program-memory writes and holds the CPU in reset
// until a complete, checksum-verified image has been loaded.
module prog_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 27_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        restart,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [9:0]  mem_ad,
  output logic [31:0] mem_din,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t r_state, w_next;

  logic [7:0]    r_cnt_lo;
  logic [10:0]   r_n;
  logic [10:0]   r_widx;
  logic [1:0]    r_bidx;
  logic [23:0]   r_shift;
  logic [7:0]    r_csum;
  logic [TW-1:0] r_tmo;
  logic          r_mem_we;
  logic [9:0]    r_mem_ad;
  logic [31:0]   r_mem_din;
  logic          r_cpu_reset;
  logic          r_done;
  logic          r_error;

  logic [10:0]   w_count;
  logic          w_count_ok;
  logic [31:0]   w_word;
  logic          w_last_word;
  logic          w_active;
  logic [TW-1:0] w_tmo_inc;
  logic          w_tmo_hit;
  logic          w_wr;

  // Byte 4 of a word completes it: the first byte received lands in [7:0].
  assign w_count     = {rx_data[2:0], r_cnt_lo};
  assign w_count_ok  = (w_count != 11'd0) && (w_count <= 11'd1024);
  assign w_word      = {rx_data, r_shift};
  assign w_last_word = ((r_widx + 11'd1) == r_n);
  assign w_active    = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_tmo_inc   = r_tmo + 1'b1;
  assign w_tmo_hit   = w_active && !rx_valid && (w_tmo_inc == TMO_MAX);

  // Next-state logic and write-request decode.
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    case (r_state)
      S_IDLE:   if (rx_valid && (rx_data == SYNC_BYTE)) w_next = S_CNT_LO;
      S_CNT_LO: if (rx_valid) w_next = S_CNT_HI;
      S_CNT_HI: if (rx_valid) w_next = w_count_ok ? S_DATA : S_ERROR;
      S_DATA: begin
        if (rx_valid && (r_bidx == 2'd3)) begin
          w_wr = 1'b1;
          if (w_last_word) w_next = S_CSUM;
        end
      end
      S_CSUM:   if (rx_valid) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
      S_DONE:   if (restart) w_next = S_IDLE;
      S_ERROR:  if (restart) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // A stalled frame overrides whatever the current state would do.
    if (w_tmo_hit) w_next = S_ERROR;
  end

  // State, status, timeout and memory-port registers (all outputs registered).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mem_we    <= 1'b0;
      r_mem_ad    <= '0;
      r_mem_din   <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_tmo       <= '0;
      r_csum      <= '0;
      r_widx      <= '0;
      r_bidx      <= '0;
    end else begin
      r_state     <= w_next;
      r_mem_we    <= w_wr;
      r_cpu_reset <= (w_next != S_DONE);
      r_done      <= (w_next == S_DONE);
      r_error     <= (w_next == S_ERROR);
      if (w_active) r_tmo <= rx_valid ? '0 : w_tmo_inc;
      else          r_tmo <= '0;
      if ((r_state == S_CNT_HI) && rx_valid) begin
        r_widx   <= '0;
        r_bidx   <= '0;
        r_csum   <= '0;
        r_mem_ad <= '0;
      end
      if ((r_state == S_DATA) && rx_valid) begin
        r_csum <= r_csum + rx_data;
        r_bidx <= r_bidx + 2'd1;
        if (w_wr) begin
          r_mem_din <= w_word;
          r_mem_ad  <= r_widx[9:0];
          r_widx    <= r_widx + 11'd1;
        end
      end
    end
  end

  // Frame payload capture; these are always rewritten before being used.
  always_ff @(posedge clk) begin
    if ((r_state == S_CNT_LO) && rx_valid) r_cnt_lo <= rx_data;
    if ((r_state == S_CNT_HI) && rx_valid) r_n <= w_count;
    if ((r_state == S_DATA) && rx_valid)   r_shift <= w_word[31:8];
  end

  assign mem_ce    = r_mem_we;
  assign mem_we    = r_mem_we;
  assign mem_ad    = r_mem_ad;
  assign mem_din   = r_mem_din;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table-driven frames, hand-written timing
// sequences, and randomized frames checked against a frame-level model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset, rx_valid, restart;
  logic [7:0]  rx_data;
  logic        mem_ce, mem_we, cpu_reset, done, error;
  logic [9:0]  mem_ad;
  logic [31:0] mem_din;

  always #5 clk = ~clk;

  prog_loader #(.TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .restart(restart), .mem_ce(mem_ce), .mem_we(mem_we), .mem_ad(mem_ad),
    .mem_din(mem_din), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  int n_vec = 0;
  int n_err = 0;
  int ce_bad = 0;
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    int         nwords;
    logic [7:0] csum_xor;
    logic       exp_done;
    logic       exp_err;
    int         exp_writes;
  } vec_t;

  vec_t tbl[9];

  // Write capture on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_ce !== mem_we) ce_bad++;
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_ad);
      wd_q.push_back(mem_din);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap_max);
    send_byte(b);
    if (gap_max > 0) idle($urandom_range(0, gap_max));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ce"}, mem_ce, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_ad"}, mem_ad, 0);
    check({tag, "_din"}, mem_din, 0);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] d[$]);
    logic [7:0] s = 8'h00;
    foreach (d[i]) s = s + d[i];
    return s;
  endfunction

  // Frame-level expectation: first exp_writes words of d, little-endian, at 0..
  task automatic check_frame(input string tag, input logic [7:0] d[$], input int exp_writes,
                             input logic exp_done, input logic exp_err);
    idle(1);
    check({tag, "_nwrites"}, wa_q.size(), exp_writes);
    for (int i = 0; i < exp_writes && i < wa_q.size(); i++) begin
      check({tag, "_ad"}, wa_q[i], i);
      check({tag, "_din"}, wd_q[i], {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
    end
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_cpu_reset"}, cpu_reset, !exp_done);
  endtask

  task automatic restart_and_check(input string tag);
    pulse_restart();
    check({tag, "_rs_done"}, done, 0);
    check({tag, "_rs_error"}, error, 0);
    check({tag, "_rs_cpu_reset"}, cpu_reset, 1);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] cs;
    int n, kind, nsend;

    reset = 1'b1; rx_valid = 1'b0; restart = 1'b0; rx_data = 8'h00;
    idle(3);
    reset = 1'b0;
    check_reset_vals("reset");

    // Basic load with exact write/completion timing.
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("basic_we_early", mem_we, 0);
    send_byte(8'h44);
    check("basic_w0_we", mem_we, 1);
    check("basic_w0_ce", mem_ce, 1);
    check("basic_w0_ad", mem_ad, 0);
    check("basic_w0_din", mem_din, 32'h44332211);
    send_byte(8'h55);
    check("basic_we_pulse", mem_we, 0);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check("basic_w1_ad", mem_ad, 1);
    check("basic_w1_din", mem_din, 32'h88776655);
    check("basic_done_early", done, 0);
    send_byte(8'h64);
    check("basic_done", done, 1);
    check("basic_cpu_reset", cpu_reset, 0);
    idle(1);
    check("basic_nwrites", wa_q.size(), 2);
    // Bytes in DONE are ignored.
    send_byte(8'hA5); send_byte(8'h01);
    check("done_hold", done, 1);

    // Restart coincident with a sync byte: the sync byte is discarded.
    rx_data = 8'hA5; rx_valid = 1'b1; restart = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; restart = 1'b0;
    check("rs_sync_done", done, 0);
    check("rs_sync_cpu_reset", cpu_reset, 1);
    clear_writes();
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_byte(8'h01); send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    send_byte(sum8(d));
    check_frame("rs_sync", d, 0, 0, 0);

    // Noise before sync, then a one-word frame.
    clear_writes();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    send_byte(8'h38);
    check_frame("noise", d, 1, 1, 0);
    check("noise_word", wd_q.size() > 0 ? wd_q[0] : 32'h0, 32'hDEADBEEF);
    restart_and_check("noise");

    // Checksum error, then restart and a correct load.
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    send_byte(8'h65);
    check("csum_err_timing", error, 1);
    check_frame("csum_err", d, 2, 0, 1);
    restart_and_check("csum_err");
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    send_byte(8'h64);
    check_frame("csum_retry", d, 2, 1, 0);
    restart_and_check("csum_retry");

    // Table of count/checksum cases with independently stated outcomes.
    tbl[0] = '{8'h01, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1};
    tbl[1] = '{8'h03, 8'h00, 3, 8'h00, 1'b1, 1'b0, 3};
    tbl[2] = '{8'h01, 8'hF8, 1, 8'h00, 1'b1, 1'b0, 1};
    tbl[3] = '{8'h00, 8'h00, 1, 8'h00, 1'b0, 1'b1, 0};
    tbl[4] = '{8'h01, 8'h04, 2, 8'h00, 1'b0, 1'b1, 0};
    tbl[5] = '{8'h00, 8'hF8, 1, 8'h00, 1'b0, 1'b1, 0};
    tbl[6] = '{8'hFF, 8'h07, 1, 8'h00, 1'b0, 1'b1, 0};
    tbl[7] = '{8'h02, 8'h00, 2, 8'h01, 1'b0, 1'b1, 2};
    tbl[8] = '{8'h05, 8'h00, 5, 8'h80, 1'b0, 1'b1, 5};
    for (int k = 0; k < 9; k++) begin
      d.delete();
      for (int j = 0; j < 4 * tbl[k].nwords; j++) d.push_back(8'(k * 37 + j * 11 + 5));
      clear_writes();
      send_byte(8'hA5); send_byte(tbl[k].lo); send_byte(tbl[k].hi);
      check($sformatf("tbl%0d_cnt_err", k), error,
            tbl[k].exp_err && (tbl[k].exp_writes == 0));
      foreach (d[i]) send_byte(d[i]);
      send_byte(sum8(d) ^ tbl[k].csum_xor);
      check_frame($sformatf("tbl%0d", k), d, tbl[k].exp_writes, tbl[k].exp_done, tbl[k].exp_err);
      restart_and_check($sformatf("tbl%0d", k));
    end

    // Full 1024-word frame, one byte per cycle, data = word index.
    d.delete();
    for (int i = 0; i < 1024; i++) begin
      d.push_back(8'(i)); d.push_back(8'(i >> 8)); d.push_back(8'h00); d.push_back(8'h00);
    end
    clear_writes();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    foreach (d[i]) send_byte(d[i]);
    send_byte(sum8(d));
    check_frame("full", d, 1024, 1, 0);
    check("full_last_ad", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 10'h0, 1023);
    restart_and_check("full");

    // Timeout after two data bytes, then no timeout while idle.
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    idle(15);
    check("tmo_early", error, 0);
    idle(1);
    check("tmo_error", error, 1);
    check("tmo_cpu_reset", cpu_reset, 1);
    check("tmo_nwrites", wa_q.size(), 0);
    restart_and_check("tmo");
    idle(40);
    check("idle_no_tmo", error, 0);

    // Reset coincident with byte 4: the write is dropped.
    clear_writes();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rx_data = 8'h44; rx_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; reset = 1'b0;
    check_reset_vals("midreset");
    idle(2);
    check("midreset_nwrites", wa_q.size(), 0);
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    foreach (d[i]) send_byte(d[i]);
    send_byte(8'h38);
    check_frame("midreset_reload", d, 1, 1, 0);
    restart_and_check("midreset");

    // Randomized frames: good, bad checksum, or bad count, with noise and gaps.
    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 2);
      if (kind == 2) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1025, 2047);
      else           n = $urandom_range(1, 6);
      nsend = (kind == 2) ? 0 : n;
      d.delete();
      for (int j = 0; j < 4 * nsend; j++) d.push_back(8'($urandom));
      cs = sum8(d);
      if (kind == 1) cs = cs ^ 8'($urandom_range(1, 255));
      clear_writes();
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        logic [7:0] nz;
        nz = 8'($urandom);
        if (nz == 8'hA5) nz = 8'h5A;
        send_gap(nz, 3);
      end
      send_gap(8'hA5, 3);
      send_gap(8'(n), 3);
      send_gap({5'($urandom), 3'(n >> 8)}, 3);
      foreach (d[i]) send_gap(d[i], 3);
      send_byte(cs);
      check_frame($sformatf("rnd%0d", r), d, (kind == 2) ? 0 : n, kind == 0, kind != 0);
      restart_and_check($sformatf("rnd%0d", r));
    end

    check("ce_eq_we", ce_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
